count_mode_ctrl: RTL and testbench

- Run/mode controller that sequences the shared up/down 4-bit counter display datapath.
- Debounces two raw push-buttons (run, mode) and generates a divided count-enable tick.
- Drives the up/down mux select and a synchronous counter-clear strobe.
- Sits between board buttons and the counter/mux/7-seg path; one instance per display.

---
 rtl/count_mode_ctrl.sv | 147 ++++++++++++++
 tb/tb_count_mode_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_mode_ctrl.sv
// Run/mode controller for the up/down counter display: debounces the run and mode buttons,
// sequences IDLE/RUN/PAUSE/SWITCH, and produces the count-enable tick, clear strobe and mux select.
module count_mode_ctrl #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btn_run,
  input  logic       btn_mode,
  output logic       select,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic [1:0] state_out
);

  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StPause  = 2'b10,
    StSwitch = 2'b11
  } state_e;

  // Bit 0 = run, bit 1 = mode.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d;
  logic [1:0]      press_q, press_d;
  logic [DebW-1:0] deb_cnt_q [2];
  logic [DebW-1:0] deb_cnt_d [2];

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            select_q, select_d;
  logic            cnt_en_q, cnt_en_d;
  logic            cnt_clr_q, cnt_clr_d;
  logic            running_q, running_d;
  logic            toggle, tick;

  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  // Mode press is tested first everywhere so a simultaneous run press is dropped.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    toggle    = 1'b0;
    tick      = 1'b0;
    cnt_clr_d = 1'b0;
    case (state_q)
      StIdle: begin
        pre_d = '0;
        if (press_q[1]) begin
          toggle    = 1'b1;
          cnt_clr_d = 1'b1;
        end else if (press_q[0]) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (pre_q == PreLast) begin
          pre_d = '0;
          tick  = 1'b1;
        end else begin
          pre_d = pre_q + PreW'(1);
        end
        if (press_q[1]) begin
          state_d = StSwitch;
        end else if (press_q[0]) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (press_q[1]) begin
          toggle    = 1'b1;
          cnt_clr_d = 1'b1;
          state_d   = StIdle;
        end else if (press_q[0]) begin
          state_d = StRun;
        end
      end
      StSwitch: begin
        pre_d     = '0;
        toggle    = 1'b1;
        cnt_clr_d = 1'b1;
        state_d   = StRun;
      end
      default: state_d = StIdle;
    endcase
    select_d  = select_q ^ toggle;
    cnt_en_d  = tick & ~cnt_clr_d;
    running_d = (state_d == StRun) || (state_d == StSwitch);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      press_q   <= '0;
      deb_cnt_q <= '{default: '0};
      state_q   <= StIdle;
      pre_q     <= '0;
      select_q  <= 1'b0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      sync1_q   <= {btn_mode, btn_run};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      press_q   <= press_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      pre_q     <= pre_d;
      select_q  <= select_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
      running_q <= running_d;
    end
  end

  assign select    = select_q;
  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign running   = running_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_count_mode_ctrl.sv
// Scoreboard bench for count_mode_ctrl: expected cnt_en/cnt_clr pulses are queued with their
// cycle, select and state; a monitor thread pops one per observed pulse.
module tb_count_mode_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       btn_run;
  logic       btn_mode;
  logic       select;
  logic       cnt_en;
  logic       cnt_clr;
  logic       running;
  logic [1:0] state_out;

  typedef struct packed {
    int unsigned cyc;
    logic        en;
    logic        clr;
    logic        sel;
    logic [1:0]  st;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  count_mode_ctrl #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .btn_run  (btn_run),
    .btn_mode (btn_mode),
    .select   (select),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .running  (running),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int unsigned c, input logic en, input logic clr, input logic sel,
                      input logic [1:0] st);
    ev_t e;
    e.cyc = c;
    e.en  = en;
    e.clr = clr;
    e.sel = sel;
    e.st  = st;
    exp_q.push_back(e);
  endtask

  task automatic at_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [1:0] st, input logic run,
                             input logic sel);
    check({name, ".state"}, 32'(state_out), 32'(st));
    check({name, ".running"}, 32'(running), 32'(run));
    check({name, ".select"}, 32'(select), 32'(sel));
  endtask

  int unsigned e0;

  initial begin
    clr_n    = 1'b0;
    btn_run  = 1'b0;
    btn_mode = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (cnt_en || cnt_clr) begin
          ev_t e;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse @cyc %0d: got en=%0b clr=%0b sel=%0b st=%0d, none expected",
                     cyc, cnt_en, cnt_clr, select, state_out);
          end else begin
            e = exp_q.pop_front();
            if ({cyc, cnt_en, cnt_clr, select, state_out} !== e) begin
              n_bad++;
              $display("FAIL pulse: got cyc=%0d en=%0b clr=%0b sel=%0b st=%0d expected cyc=%0d en=%0b clr=%0b sel=%0b st=%0d",
                       cyc, cnt_en, cnt_clr, select, state_out, e.cyc, e.en, e.clr, e.sel, e.st);
            end
          end
        end
      end
    join_none

    // Reset held with buttons toggling: every output stays at its reset value.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      btn_run  = i[0];
      btn_mode = i[1];
      @(negedge clk);
      check_state("reset", 2'b00, 1'b0, 1'b0);
      check("reset.cnt_en", 32'(cnt_en), 32'd0);
      check("reset.cnt_clr", 32'(cnt_clr), 32'd0);
    end
    btn_run  = 1'b0;
    btn_mode = 1'b0;
    clr_n    = 1'b1;
    at_cyc(cyc + 12);
    check_state("post_reset", 2'b00, 1'b0, 1'b0);

    // Run glitch (2 high, 1 low) then a stable rise at e0-6: RUN entered at e0.
    e0 = cyc + 9;
    btn_run = 1'b1;
    at_cyc(e0 - 7);
    btn_run = 1'b0;
    at_cyc(e0 - 6);
    btn_run = 1'b1;

    for (int n = 1; n <= 5; n++) push(e0 + 4 * n, 1'b1, 1'b0, 1'b0, 2'b01);
    for (int n = 0; n < 3; n++) push(e0 + 36 + 4 * n, 1'b1, 1'b0, 1'b0, 2'b01);
    push(e0 + 47, 1'b0, 1'b1, 1'b1, 2'b01);
    push(e0 + 51, 1'b1, 1'b0, 1'b1, 2'b01);
    push(e0 + 55, 1'b1, 1'b0, 1'b1, 2'b01);
    push(e0 + 70, 1'b0, 1'b1, 1'b0, 2'b00);
    push(e0 + 86, 1'b0, 1'b1, 1'b1, 2'b00);
    push(e0 + 106, 1'b1, 1'b0, 1'b1, 2'b01);
    push(e0 + 116, 1'b0, 1'b1, 1'b1, 2'b00);

    at_cyc(e0 - 1);
    check_state("deb_before", 2'b00, 1'b0, 1'b0);
    at_cyc(e0);
    check_state("deb_run", 2'b01, 1'b1, 1'b0);
    at_cyc(e0 + 4);
    btn_run = 1'b0;

    // Pause with prescaler at 2, resume 12 cycles later.
    at_cyc(e0 + 16);
    btn_run = 1'b1;
    at_cyc(e0 + 22);
    btn_run = 1'b0;
    check_state("pause", 2'b10, 1'b0, 1'b0);
    at_cyc(e0 + 28);
    btn_run = 1'b1;
    at_cyc(e0 + 34);
    btn_run = 1'b0;
    check_state("resume", 2'b01, 1'b1, 1'b0);

    // Mode press in RUN: one SWITCH cycle, then clear with select flipped.
    at_cyc(e0 + 40);
    btn_mode = 1'b1;
    at_cyc(e0 + 46);
    btn_mode = 1'b0;
    check_state("switch", 2'b11, 1'b1, 1'b0);
    at_cyc(e0 + 47);
    check_state("switch_done", 2'b01, 1'b1, 1'b1);

    // Pause, then simultaneous run+mode: mode wins, back to IDLE.
    at_cyc(e0 + 52);
    btn_run = 1'b1;
    at_cyc(e0 + 58);
    btn_run = 1'b0;
    check_state("pause2", 2'b10, 1'b0, 1'b1);
    at_cyc(e0 + 64);
    btn_run  = 1'b1;
    btn_mode = 1'b1;
    at_cyc(e0 + 70);
    btn_run  = 1'b0;
    btn_mode = 1'b0;
    check_state("both", 2'b00, 1'b0, 1'b0);
    at_cyc(e0 + 76);
    check_state("both_after", 2'b00, 1'b0, 1'b0);

    // Mode press in IDLE: toggle and clear, remain IDLE.
    at_cyc(e0 + 80);
    btn_mode = 1'b1;
    at_cyc(e0 + 86);
    btn_mode = 1'b0;
    check_state("idle_mode", 2'b00, 1'b0, 1'b1);

    // Into RUN, then reset mid-run with a mode press half debounced.
    at_cyc(e0 + 96);
    btn_run = 1'b1;
    at_cyc(e0 + 102);
    btn_run = 1'b0;
    check_state("run2", 2'b01, 1'b1, 1'b1);
    at_cyc(e0 + 104);
    btn_mode = 1'b1;
    at_cyc(e0 + 108);
    #2;
    clr_n = 1'b0;
    #1;
    check_state("midreset", 2'b00, 1'b0, 1'b0);
    check("midreset.cnt_en", 32'(cnt_en), 32'd0);
    check("midreset.cnt_clr", 32'(cnt_clr), 32'd0);
    at_cyc(e0 + 110);
    clr_n = 1'b1;
    at_cyc(e0 + 115);
    check_state("relearn_before", 2'b00, 1'b0, 1'b0);
    at_cyc(e0 + 118);
    btn_mode = 1'b0;
    at_cyc(e0 + 126);
    check_state("final", 2'b00, 1'b0, 1'b1);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_pulse: got none expected cyc=%0d en=%0b clr=%0b sel=%0b st=%0d",
               e.cyc, e.en, e.clr, e.sel, e.st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
